// File: rtl/ram_bus_ctrl_pkg.sv
// ram_bus_ctrl_pkg
//   Shared widths, load/store type codes, controller state codes and the
//   debug view used by the RAM bus controller and its load extender.
package ram_bus_ctrl_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int ROB_WIDTH         = 4;
  localparam int INST_TYPE_WIDTH   = 4;

  // Load / store type codes (one code space shared by both paths).
  localparam logic [INST_TYPE_WIDTH-1:0] LB  = 4'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] LH  = 4'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] LW  = 4'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] LBU = 4'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] LHU = 4'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] SB  = 4'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] SH  = 4'd6;
  localparam logic [INST_TYPE_WIDTH-1:0] SW  = 4'd7;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [INSTRUCTION_WIDTH-1:0] NULL = '0;

  typedef enum logic [1:0] {
    MEMCTRL_IDLE  = 2'd0,
    MEMCTRL_LOAD  = 2'd1,
    MEMCTRL_STORE = 2'd2
  } memctrl_state_e;

  // Debug view of the controller: FSM state, byte counter and latched tag.
  typedef struct packed {
    memctrl_state_e       state;
    logic [2:0]           byte_cnt;
    logic [ROB_WIDTH-1:0] dest;
  } memctrl_dbg_t;

  // Number of bytes moved for a given load/store type.
  function automatic logic [2:0] access_len(input logic [INST_TYPE_WIDTH-1:0] t);
    logic [2:0] n;
    case (t)
      LB, LBU, SB: n = 3'd1;
      LH, LHU, SH: n = 3'd2;
      default:     n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ram_bus_ctrl_load_extend.sv
// load_extend
//   Combinational sign/zero extension of an assembled little-endian load word.
//   Ports:
//     word_in      : assembled bytes, byte 0 in [7:0]
//     inst_type_in : LB, LH, LW, LBU or LHU
//     data_out     : extended result
module load_extend
  import ram_bus_ctrl_pkg::*;
(
  input  logic [INSTRUCTION_WIDTH-1:0] word_in,
  input  logic [INST_TYPE_WIDTH-1:0]   inst_type_in,
  output logic [INSTRUCTION_WIDTH-1:0] data_out
);

  always_comb begin
    data_out = word_in;
    case (inst_type_in)
      LB:      data_out = {{24{word_in[7]}}, word_in[7:0]};
      LH:      data_out = {{16{word_in[15]}}, word_in[15:0]};
      LBU:     data_out = {24'h000000, word_in[7:0]};
      LHU:     data_out = {16'h0000, word_in[15:0]};
      default: data_out = word_in;
    endcase
  end

endmodule

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl
//   Responder for load-buffer loads and ROB committed stores. Each access is
//   broken into byte cycles on a single-port 8-bit RAM (read data arrives the
//   cycle after its address). Load results come back extended with a
//   one-cycle pulse; stores pulse done after their last byte is written.
//   Ports:
//     clk_in, rst_in (sync, active-high), rdy_in (low = freeze everything)
//     rob_flush_in                 : mispredict flush (aborts loads only)
//     lbuffer_*                    : load request / ready / result pulse
//     rob_store_*                  : store request / ready / done pulse
//     io_buffer_full_in            : stalls stores into the I/O region
//     mem_din/mem_dout/mem_a/mem_wr: RAM pins
//     dbg_out                      : FSM state, byte counter and tag
//
//   Handshake: a request transfers at a rising edge where its en input and
//   the matching rdy output are both high (and rdy_in is high). Requests are
//   only taken in IDLE; store wins when both are offered. The result and done
//   outputs are single-cycle pulses with no back-pressure.
module ram_bus_ctrl
  import ram_bus_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         rob_flush_in,
  input  logic                         lbuffer_en_in,
  input  logic [INSTRUCTION_WIDTH-1:0] lbuffer_A_in,
  input  logic [ROB_WIDTH-1:0]         lbuffer_dest_in,
  input  logic [INST_TYPE_WIDTH-1:0]   lbuffer_inst_type_in,
  output logic                         lbuffer_rdy_out,
  output logic                         lbuffer_data_en_out,
  output logic [INSTRUCTION_WIDTH-1:0] lbuffer_data_out,
  input  logic                         rob_store_en_in,
  input  logic [INSTRUCTION_WIDTH-1:0] rob_store_A_in,
  input  logic [INSTRUCTION_WIDTH-1:0] rob_store_data_in,
  input  logic [INST_TYPE_WIDTH-1:0]   rob_store_inst_type_in,
  output logic                         rob_store_rdy_out,
  output logic                         rob_store_done_out,
  input  logic                         io_buffer_full_in,
  input  logic [7:0]                   mem_din,
  output logic [7:0]                   mem_dout,
  output logic [31:0]                  mem_a,
  output logic                         mem_wr,
  output memctrl_dbg_t                 dbg_out
);

  memctrl_state_e state_q, state_d;

  // cnt_q: cycle index since acceptance. For stores it equals the byte being
  // written; for loads byte cnt_q-1 is on mem_din at the end of cycle cnt_q.
  logic [2:0]                   cnt_q;
  logic [2:0]                   len_q;
  logic [INST_TYPE_WIDTH-1:0]   type_q;
  logic [ROB_WIDTH-1:0]         dest_q;
  logic                         io_q;      // store targets the I/O region
  logic [23:0]                  sdata_q;   // store bytes not yet presented
  logic [INSTRUCTION_WIDTH-1:0] word_q;    // load bytes gathered so far
  logic [INSTRUCTION_WIDTH-1:0] word_next;
  logic [INSTRUCTION_WIDTH-1:0] ext_data;

  logic accept_store;
  logic accept_load;
  logic io_stall;
  logic load_last;
  logic store_last;

  assign accept_store = (state_q == MEMCTRL_IDLE) && rob_store_en_in && !rob_flush_in;
  assign accept_load  = (state_q == MEMCTRL_IDLE) && lbuffer_en_in && !rob_store_en_in
                        && !rob_flush_in;
  assign io_stall     = io_q && io_buffer_full_in;
  assign load_last    = (cnt_q == len_q);
  assign store_last   = (cnt_q == 3'(len_q - 3'd1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= MEMCTRL_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEMCTRL_IDLE: begin
        if (accept_store) begin
          state_d = MEMCTRL_STORE;
        end else if (accept_load) begin
          state_d = MEMCTRL_LOAD;
        end
      end
      MEMCTRL_LOAD: begin
        if (rob_flush_in || load_last) begin
          state_d = MEMCTRL_IDLE;
        end
      end
      MEMCTRL_STORE: begin
        // Committed stores ignore flush; only the I/O stall holds them.
        if (!io_stall && store_last) begin
          state_d = MEMCTRL_IDLE;
        end
      end
      default: state_d = MEMCTRL_IDLE;
    endcase
  end

  always_comb begin
    lbuffer_rdy_out   = (state_q == MEMCTRL_IDLE) && !rst_in && !rob_flush_in;
    rob_store_rdy_out = (state_q == MEMCTRL_IDLE) && !rst_in && !rob_flush_in;
    // Gated by rdy_in so a frozen cycle never repeats a write.
    mem_wr            = (state_q == MEMCTRL_STORE) && !io_stall && rdy_in && !rst_in;
  end

  // ------------------------------------------------------ load assembly
  // Merge the byte currently on mem_din so the final byte can be extended
  // in the same edge that raises the result pulse.
  always_comb begin
    word_next = word_q;
    case (cnt_q)
      3'd1:    word_next[7:0]   = mem_din;
      3'd2:    word_next[15:8]  = mem_din;
      3'd3:    word_next[23:16] = mem_din;
      3'd4:    word_next[31:24] = mem_din;
      default: word_next = word_q;
    endcase
  end

  load_extend u_load_extend (
    .word_in      (word_next),
    .inst_type_in (type_q),
    .data_out     (ext_data)
  );

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q               <= '0;
      len_q               <= '0;
      type_q              <= '0;
      dest_q              <= '0;
      io_q                <= 1'b0;
      sdata_q             <= '0;
      word_q              <= '0;
      mem_a               <= '0;
      mem_dout            <= '0;
      lbuffer_data_out    <= '0;
      lbuffer_data_en_out <= 1'b0;
      rob_store_done_out  <= 1'b0;
    end else if (rdy_in) begin
      lbuffer_data_en_out <= 1'b0;
      rob_store_done_out  <= 1'b0;
      case (state_q)
        MEMCTRL_IDLE: begin
          if (accept_store) begin
            cnt_q    <= '0;
            len_q    <= access_len(rob_store_inst_type_in);
            type_q   <= rob_store_inst_type_in;
            io_q     <= (rob_store_A_in[17:16] == IO_ADDR_HI);
            mem_a    <= rob_store_A_in;
            mem_dout <= rob_store_data_in[7:0];
            sdata_q  <= rob_store_data_in[31:8];
          end else if (accept_load) begin
            cnt_q  <= '0;
            len_q  <= access_len(lbuffer_inst_type_in);
            type_q <= lbuffer_inst_type_in;
            dest_q <= lbuffer_dest_in;
            io_q   <= 1'b0;
            mem_a  <= lbuffer_A_in;
            word_q <= '0;
          end
        end
        MEMCTRL_LOAD: begin
          if (rob_flush_in) begin
            cnt_q <= '0;
          end else if (load_last) begin
            cnt_q               <= '0;
            lbuffer_data_out    <= ext_data;
            lbuffer_data_en_out <= 1'b1;
          end else begin
            word_q <= word_next;
            cnt_q  <= 3'(cnt_q + 3'd1);
            // Addresses stop advancing once the last byte has been issued.
            if (3'(cnt_q + 3'd1) < len_q) begin
              mem_a <= mem_a + 32'd1;
            end
          end
        end
        MEMCTRL_STORE: begin
          if (!io_stall) begin
            if (store_last) begin
              cnt_q              <= '0;
              rob_store_done_out <= 1'b1;
            end else begin
              cnt_q    <= 3'(cnt_q + 3'd1);
              mem_a    <= mem_a + 32'd1;
              mem_dout <= sdata_q[7:0];
              sdata_q  <= {8'h00, sdata_q[23:8]};
            end
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign dbg_out = '{state: state_q, byte_cnt: cnt_q, dest: dest_q};

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// tb_ram_bus_ctrl
//   Directed bench for ram_bus_ctrl: a byte RAM responder, a transaction
//   model that predicts every output each cycle, and a queue of literal load
//   results that pins the model.
module tb_ram_bus_ctrl;
  import ram_bus_ctrl_pkg::*;

  // ------------------------------------------------ clock / reset block
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in, rdy_in, rob_flush_in;
  logic        lbuffer_en_in;
  logic [31:0] lbuffer_A_in;
  logic [3:0]  lbuffer_dest_in;
  logic [3:0]  lbuffer_inst_type_in;
  logic        lbuffer_rdy_out, lbuffer_data_en_out;
  logic [31:0] lbuffer_data_out;
  logic        rob_store_en_in;
  logic [31:0] rob_store_A_in, rob_store_data_in;
  logic [3:0]  rob_store_inst_type_in;
  logic        rob_store_rdy_out, rob_store_done_out;
  logic        io_buffer_full_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  memctrl_dbg_t dbg;

  ram_bus_ctrl #(.IO_ADDR_HI(2'b11)) dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .rob_flush_in           (rob_flush_in),
    .lbuffer_en_in          (lbuffer_en_in),
    .lbuffer_A_in           (lbuffer_A_in),
    .lbuffer_dest_in        (lbuffer_dest_in),
    .lbuffer_inst_type_in   (lbuffer_inst_type_in),
    .lbuffer_rdy_out        (lbuffer_rdy_out),
    .lbuffer_data_en_out    (lbuffer_data_en_out),
    .lbuffer_data_out       (lbuffer_data_out),
    .rob_store_en_in        (rob_store_en_in),
    .rob_store_A_in         (rob_store_A_in),
    .rob_store_data_in      (rob_store_data_in),
    .rob_store_inst_type_in (rob_store_inst_type_in),
    .rob_store_rdy_out      (rob_store_rdy_out),
    .rob_store_done_out     (rob_store_done_out),
    .io_buffer_full_in      (io_buffer_full_in),
    .mem_din                (mem_din),
    .mem_dout               (mem_dout),
    .mem_a                  (mem_a),
    .mem_wr                 (mem_wr),
    .dbg_out                (dbg)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------ RAM responder
  bit [7:0] ram   [int unsigned];
  bit [7:0] ram_m [int unsigned];
  int wr_cnt = 0;

  always @(posedge clk_in) begin
    if (mem_wr === 1'b1) begin
      ram[mem_a] = mem_dout;
      wr_cnt++;
    end
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]   = b;
    ram_m[a] = b;
  endtask

  // ---------------------------------------------------------- the model
  function automatic bit [7:0] rd_m(input logic [31:0] a);
    return ram_m.exists(a) ? ram_m[a] : 8'h00;
  endfunction

  function automatic int len_of(input logic [3:0] t);
    if (t == LB || t == LBU || t == SB) return 1;
    if (t == LH || t == LHU || t == SH) return 2;
    return 4;
  endfunction

  // Value a load must return, straight from the model RAM.
  function automatic logic [31:0] load_value(input logic [31:0] a, input logic [3:0] t);
    logic [31:0] w;
    w = {rd_m(a + 32'd3), rd_m(a + 32'd2), rd_m(a + 32'd1), rd_m(a)};
    case (t)
      LB:      return (w[7]  ? 32'hFFFFFF00 : 32'h0) | (w & 32'h000000FF);
      LH:      return (w[15] ? 32'hFFFF0000 : 32'h0) | (w & 32'h0000FFFF);
      LBU:     return w & 32'h000000FF;
      LHU:     return w & 32'h0000FFFF;
      default: return w;
    endcase
  endfunction

  // m_st: 0 idle, 1 serving a load, 2 serving a store.
  // m_k : cycles elapsed since acceptance (load) / byte in flight (store).
  int          m_st = 0, m_k = 0, m_n = 0;
  logic [31:0] m_a, m_data, m_val;
  bit          m_io = 0;
  logic [31:0] e_mem_a = 0, e_ldata = 0;
  bit          e_len = 0, e_done = 0, started = 0;

  always @(posedge clk_in) begin
    started = 1;
    if (rst_in) begin
      m_st = 0; m_k = 0; e_mem_a = 0; e_ldata = 0; e_len = 0; e_done = 0;
    end else if (rdy_in) begin
      e_len  = 0;
      e_done = 0;
      case (m_st)
        0: if (!rob_flush_in) begin
          if (rob_store_en_in) begin
            m_st = 2; m_k = 0; m_a = rob_store_A_in; m_data = rob_store_data_in;
            m_n = len_of(rob_store_inst_type_in);
            m_io = (rob_store_A_in[17:16] == 2'b11);
            e_mem_a = rob_store_A_in;
          end else if (lbuffer_en_in) begin
            m_st = 1; m_k = 0; m_a = lbuffer_A_in;
            m_n = len_of(lbuffer_inst_type_in);
            m_val = load_value(lbuffer_A_in, lbuffer_inst_type_in);
            e_mem_a = lbuffer_A_in;
          end
        end
        1: if (rob_flush_in) begin
          m_st = 0;
        end else begin
          m_k++;
          if (m_k == m_n + 1) begin
            m_st = 0; e_len = 1; e_ldata = m_val;
          end else if (m_k < m_n) begin
            e_mem_a = m_a + 32'(m_k);
          end
        end
        default: if (!(m_io && io_buffer_full_in)) begin
          ram_m[m_a + 32'(m_k)] = m_data[8*m_k +: 8];
          if (m_k == m_n - 1) begin
            m_st = 0; e_done = 1;
          end else begin
            m_k++;
            e_mem_a = m_a + 32'(m_k);
          end
        end
      endcase
    end
  end

  // ------------------------------------------- scoreboard / compare
  logic [31:0] exp_q[$];

  always @(negedge clk_in) begin
    if (started) begin
      chk1("lbuffer_rdy", lbuffer_rdy_out, (m_st == 0) && !rst_in && !rob_flush_in);
      chk1("store_rdy", rob_store_rdy_out, (m_st == 0) && !rst_in && !rob_flush_in);
      chk1("mem_wr", mem_wr,
           (m_st == 2) && rdy_in && !rst_in && !(m_io && io_buffer_full_in));
      chk1("data_en", lbuffer_data_en_out, e_len);
      chk1("store_done", rob_store_done_out, e_done);
      chk32("mem_a", mem_a, e_mem_a);
      chk32("data_out", lbuffer_data_out, e_ldata);
      if ((m_st == 2) && rdy_in && !rst_in && !(m_io && io_buffer_full_in))
        chk32("mem_dout", {24'h0, mem_dout}, {24'h0, m_data[8*m_k +: 8]});
      if (lbuffer_data_en_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_pulse: got pulse data %h expected no pulse", lbuffer_data_out);
        end else begin
          chk32("sb_load", lbuffer_data_out, exp_q.pop_front());
        end
      end
    end
  end

  // ------------------------------------------------------ driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  // Wait for the load pulse; 'lat' is how many more negedges must pass
  // before it (0 = the very next one). Timeout reads as -1.
  task automatic wait_load(input int lat, input string name);
    int n = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (lbuffer_data_en_out === 1'b1) begin n = i; break; end
    end
    chk32(name, 32'(n), 32'(lat));
  endtask

  task automatic wait_done(input int lat, input string name);
    int n = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (rob_store_done_out === 1'b1) begin n = i; break; end
    end
    chk32(name, 32'(n), 32'(lat));
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      if (lbuffer_data_en_out === 1'b1) n++;
    end
  endtask

  task automatic load_req(input logic [31:0] a, input logic [3:0] t);
    lbuffer_en_in = 1; lbuffer_A_in = a; lbuffer_inst_type_in = t;
    lbuffer_dest_in = 4'(a[3:0] + 4'd1);
  endtask

  task automatic store_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    rob_store_en_in = 1; rob_store_A_in = a; rob_store_data_in = d;
    rob_store_inst_type_in = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100us");
    $fatal(1);
  end

  // ------------------------------------------------------------ stimulus
  initial begin : stim
    logic [7:0] sw_bytes [4];
    int n;
    int w0;
    sw_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rst_in = 1; rdy_in = 1; rob_flush_in = 0; io_buffer_full_in = 0;
    lbuffer_en_in = 0; lbuffer_A_in = 0; lbuffer_dest_in = 0; lbuffer_inst_type_in = 0;
    rob_store_en_in = 0; rob_store_A_in = 0; rob_store_data_in = 0;
    rob_store_inst_type_in = 0;

    // Reset state.
    tick(2);
    @(negedge clk_in);
    chk32("rst_mem_a", mem_a, 32'h0);
    chk32("rst_dout", {24'h0, mem_dout}, 32'h0);
    chk32("rst_data", lbuffer_data_out, 32'h0);
    chk1("rst_wr", mem_wr, 1'b0);
    chk1("rst_rdy", lbuffer_rdy_out, 1'b0);
    tick(1);
    rst_in = 0;
    @(negedge clk_in);
    chk1("post_rst_rdy", lbuffer_rdy_out, 1'b1);
    tick(1);

    // LW at 0x100 holding 78 56 34 12.
    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    exp_q.push_back(32'h12345678);
    load_req(32'h100, LW);
    tick(1);
    lbuffer_en_in = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk32("lw_addr", mem_a, 32'h100 + 32'(k));
    end
    wait_load(1, "lw_latency");

    // LB then LBU at 0x200 (0x80), second taken in the first pulse cycle.
    preload(32'h200, 8'h80);
    exp_q.push_back(32'hFFFFFF80);
    exp_q.push_back(32'h00000080);
    tick(1);
    load_req(32'h200, LB);
    tick(1);
    lbuffer_inst_type_in = LBU;
    wait_load(2, "lb_latency");
    chk1("b2b_rdy_in_pulse", lbuffer_rdy_out, 1'b1);
    tick(1);
    lbuffer_en_in = 0;
    wait_load(2, "lbu_latency");

    // Store and load offered together: store first, then LH reads it back.
    preload(32'h300, 8'h00); preload(32'h301, 8'h00);
    preload(32'h302, 8'h00); preload(32'h303, 8'h00);
    exp_q.push_back(32'hFFFFBEEF);
    tick(1);
    store_req(32'h300, 32'hDEADBEEF, SW);
    load_req(32'h300, LH);
    tick(1);
    rob_store_en_in = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk1("sw_wr", mem_wr, 1'b1);
      chk32("sw_addr", mem_a, 32'h300 + 32'(k));
      chk32("sw_byte", {24'h0, mem_dout}, {24'h0, sw_bytes[k]});
    end
    wait_done(0, "sw_done");
    tick(1);
    lbuffer_en_in = 0;
    wait_load(3, "lh_latency");

    // SB into the I/O region while the UART buffer is full for 3 cycles.
    tick(1);
    io_buffer_full_in = 1;
    store_req(32'h30000, 32'h00000041, SB);
    tick(1);
    rob_store_en_in = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk1("io_stall_wr", mem_wr, 1'b0);
    end
    tick(1);
    io_buffer_full_in = 0;
    @(negedge clk_in);
    chk1("io_wr", mem_wr, 1'b1);
    chk32("io_addr", mem_a, 32'h30000);
    chk32("io_byte", {24'h0, mem_dout}, 32'h41);
    wait_done(0, "io_done");

    // LW flushed in cycle 2: no pulse, ready again in cycle 3.
    tick(1);
    load_req(32'h100, LW);
    tick(1);
    lbuffer_en_in = 0;
    tick(2);
    rob_flush_in = 1;
    tick(1);
    rob_flush_in = 0;
    @(negedge clk_in);
    chk1("flush_rdy", lbuffer_rdy_out, 1'b1);
    count_pulses(6, n);
    chk32("flush_no_pulse", 32'(n), 32'h0);

    // SH with flush held: both bytes still written.
    tick(1);
    store_req(32'h400, 32'h1234CAFE, SH);
    tick(1);
    rob_store_en_in = 0;
    rob_flush_in = 1;
    wait_done(2, "sh_flush_done");
    tick(1);
    rob_flush_in = 0;

    // Reset in the middle of an LW.
    load_req(32'h100, LW);
    tick(1);
    lbuffer_en_in = 0;
    tick(2);
    rst_in = 1;
    tick(1);
    @(negedge clk_in);
    chk32("midrst_mem_a", mem_a, 32'h0);
    chk1("midrst_en", lbuffer_data_en_out, 1'b0);
    tick(1);
    rst_in = 0;
    count_pulses(8, n);
    chk32("midrst_no_pulse", 32'(n), 32'h0);

    // rdy_in low for two cycles in the middle of an SW.
    tick(1);
    w0 = wr_cnt;
    store_req(32'h500, 32'h11223344, SW);
    tick(1);
    rob_store_en_in = 0;
    tick(1);
    rdy_in = 0;
    @(negedge clk_in);
    chk32("frz_addr1", mem_a, 32'h501);
    chk1("frz_wr1", mem_wr, 1'b0);
    tick(1);
    @(negedge clk_in);
    chk32("frz_addr2", mem_a, 32'h501);
    chk1("frz_wr2", mem_wr, 1'b0);
    tick(1);
    rdy_in = 1;
    wait_done(3, "frz_done");
    chk32("frz_write_count", 32'(wr_cnt - w0), 32'd4);
    tick(2);

    // Final memory image.
    chk32("ram_303", {24'h0, ram[32'h303]}, 32'hDE);
    chk32("ram_30000", {24'h0, ram[32'h30000]}, 32'h41);
    chk32("ram_401", {24'h0, ram[32'h401]}, 32'hCA);
    chk32("ram_500", {24'h0, ram[32'h500]}, 32'h44);
    chk32("ram_503", {24'h0, ram[32'h503]}, 32'h11);
    foreach (ram_m[a]) chk32("ram_image", {24'h0, ram[a]}, {24'h0, ram_m[a]});
    chk32("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bus_ctrl.md
Name: ram_bus_ctrl

Overview:
- Responder end of the load-buffer RAM bus and of the ROB store-commit path.
- Serialises each load or store into byte accesses on the single-port 8-bit RAM.
- Returns load results already sign/zero-extended, with a one-cycle data pulse.
- Sits between LBuffer/ROB and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- IO_ADDR_HI, 2'b11, value of address[17:16] that marks the I/O region (stores there obey io_buffer_full_in).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; synchronous, active-high.
- rdy_in  input  1  global enable; low freezes all state.
- rob_flush_in  input  1  mispredict flush.
- lbuffer_en_in  input  1  load request valid.
- lbuffer_A_in  input  `INSTRUCTION_WIDTH  load byte address.
- lbuffer_dest_in  input  `ROB_WIDTH  ROB tag, latched for the transaction.
- lbuffer_inst_type_in  input  `INST_TYPE_WIDTH  load type: LB, LH, LW, LBU or LHU.
- lbuffer_rdy_out  output  1  may accept a load this cycle.
- lbuffer_data_en_out  output  1  one-cycle result-valid pulse.
- lbuffer_data_out  output  `INSTRUCTION_WIDTH  extended load result.
- rob_store_en_in  input  1  committed store valid.
- rob_store_A_in  input  `INSTRUCTION_WIDTH  store byte address.
- rob_store_data_in  input  `INSTRUCTION_WIDTH  store data.
- rob_store_inst_type_in  input  `INST_TYPE_WIDTH  store type: SB, SH or SW.
- rob_store_rdy_out  output  1  may accept a store this cycle.
- rob_store_done_out  output  1  one-cycle pulse when the last byte has been written.
- io_buffer_full_in  input  1  UART buffer full.
- mem_din  input  8  RAM read data, valid the cycle after its address.
- mem_dout  output  8  RAM write data.
- mem_a  output  32  RAM address.
- mem_wr  output  1  RAM write strobe; 1 = write.

Behaviour:
- Reset and rdy:
  - Reset: state IDLE; every output 0, including mem_a and the pulses; byte counter 0.
  - rdy_in low: all registers hold. mem_wr is gated low combinationally, so no repeated writes.
- States:
  - IDLE: both rdy outputs = (state==IDLE && !rst_in && !rob_flush_in).
  - LOAD / STORE: both rdy outputs low.
- Arbitration in IDLE:
  - Store has priority if both are valid.
  - A request is accepted at edge E0 when en && rdy. Address, type, tag and data are sampled at E0.
- Length N: 1 for B types, 2 for H types, 4 for W.
- Addressing: byte addressed, no alignment requirement; addresses wrap modulo 2^32.
- LOAD:
  - During cycle k (k=0..N-1 after E0): mem_a = A+k, mem_wr = 0.
  - Byte k is sampled from mem_din at edge E(k+2).
  - Bytes assemble little-endian.
  - At edge E(N+1): lbuffer_data_out <= extended value; lbuffer_data_en_out <= 1 for exactly one cycle; state -> IDLE.
  - Latency: result pulse in cycle N+1 (LB/LBU 2 cycles, LH/LHU 3, LW 5).
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW as is.
- STORE:
  - During cycle k: mem_a = A+k, mem_dout = data[8k+7:8k], mem_wr = 1.
  - Exception: if A[17:16]==IO_ADDR_HI and io_buffer_full_in, then mem_wr = 0 and k holds (stall) until not full.
  - After byte N-1 is written: rob_store_done_out pulses for one cycle and state -> IDLE. With no stall, that is cycle N.
- Flush:
  - rob_flush_in in LOAD: abort. State -> IDLE next edge, mem_wr 0, no lbuffer_data_en_out pulse, even if the final byte arrives that edge.
  - rob_flush_in in STORE: ignored, because committed stores always complete.
  - rob_flush_in in IDLE: blocks acceptance that cycle.
- Simultaneous events:
  - A data_en pulse and a new acceptance cannot share a cycle. rdy rises only in the pulse cycle itself (state IDLE), so back-to-back service is allowed.
- Idle outputs: mem_wr = 0; mem_a holds its last value.
- Reset mid-transaction: abandons it immediately, with no pulse.

Decomposition:
- Shared define.vh holds:
  - INSTRUCTION_WIDTH, ROB_WIDTH, INST_TYPE_WIDTH.
  - LB, LH, LW, LBU, LHU, SB, SH, SW codes.
  - ENABLE, DISABLE, NULL.
  - New MEMCTRL_IDLE, MEMCTRL_LOAD, MEMCTRL_STORE state codes.
- One combinational sub-module, load_extend: 32-bit assembled word plus type in, extended result out.

Test Plan:
- LW at A=0x100, RAM bytes 0x100..0x103 = 78 56 34 12 -> mem_a 100,101,102,103 in cycles 0-3; data_en in cycle 5 only, data 0x12345678.
- LB at A=0x200 holding 0x80, then LBU same address back-to-back -> results 0xFFFFFF80 then 0x00000080; the second is accepted in the cycle of the first pulse.
- Store SW 0xDEADBEEF to 0x300 and load LH 0x300 both valid in the same IDLE cycle -> store first; writes EF,BE,AD,DE at 0x300..0x303; done in cycle 4; load is then accepted and returns 0xFFFFBEEF.
- SB 0x41 to 0x30000 with io_buffer_full_in high for 3 cycles -> mem_wr stays 0 for 3 cycles, one write once full drops, done next cycle.
- LW in progress, rob_flush_in at cycle 2 -> no data_en; rdy high next cycle. SH in progress with flush -> both bytes written, done pulses.
- rst_in asserted mid-LW and rdy_in low for 2 cycles mid-SW (separate runs) -> reset clears all outputs next edge; rdy stall holds mem_a with mem_wr 0 and resumes with no duplicate byte.
